// File: rtl/ps2_send_scheduler_pkg.sv
// Shared definitions for the PS/2 device-send scheduler: FSM state codes,
// device reply bytes and a small classifier for those replies.
package ps2_send_scheduler_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_LOAD     = 4'd1;
    localparam state_t ST_KICK     = 4'd2;
    localparam state_t ST_XMIT     = 4'd3;
    localparam state_t ST_WAIT_ACK = 4'd4;
    localparam state_t ST_GAP      = 4'd5;   // one low cycle so a resend gets a fresh rising edge
    localparam state_t ST_NEXT     = 4'd6;
    localparam state_t ST_DONE     = 4'd7;
    localparam state_t ST_ABORT    = 4'd8;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    // True for the two bytes the scheduler swallows while waiting for a reply.
    function automatic logic is_reply(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_RESEND);
    endfunction

endpackage

// File: rtl/ps2_send_scheduler_arbiter.sv
// Two-way round-robin arbiter with a lock. bit 0 of req is requester A,
// bit 1 is requester B; grant 0 means A, 1 means B. The grant is captured
// while unlocked and held while locked; last_grant only moves when the
// owning command finishes.
module ps2_rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       update,
    output logic       grant,
    output logic       pick
);

    logic grant_reg;
    logic last_reg;

    // On a tie the requester that did not finish last wins.
    assign pick  = (req == 2'b11) ? ~last_reg : req[1];
    assign grant = grant_reg;

    // Grant capture while unlocked, history update on command completion.
    always_ff @(negedge clock) begin
        if (reset) begin
            grant_reg <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            if (!lock && (req != 2'b00)) begin
                grant_reg <= pick;
            end
            if (update) begin
                last_reg <= grant_reg;
            end
        end
    end

endmodule

// File: rtl/ps2_send_scheduler.sv
// PS/2 device-send scheduler: arbitrates two command sources, sends each
// command byte through the transmitter, waits for ACK/RESEND with retry
// and timeout, and forwards every other received byte to the scancode path.
module ps2_send_scheduler
    import ps2_send_scheduler_pkg::*;
#(
    parameter logic [19:0] ACK_TIMEOUT   = 20'd200000,
    parameter logic [15:0] START_TIMEOUT = 16'd64,
    parameter logic [1:0]  MAX_RETRY     = 2'd3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_a_valid,
    input  logic [7:0] req_a_data,
    input  logic       req_a_last,
    output logic       req_a_ready,
    input  logic       req_b_valid,
    input  logic [7:0] req_b_data,
    input  logic       req_b_last,
    output logic       req_b_ready,
    output logic       send_request,
    output logic [7:0] send_data,
    input  logic       sending_data_flag,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       fwd_valid,
    output logic [7:0] fwd_data,
    output logic       done_valid,
    output logic       done_src,
    output logic       done_error,
    output logic       busy
);

    state_t      state_reg;
    state_t      state_next;
    logic [19:0] cnt_reg;
    logic [1:0]  retry_reg;
    logic [1:0]  retry_next;
    logic [7:0]  data_reg;
    logic        last_reg;
    logic        fwd_valid_reg;
    logic [7:0]  fwd_data_reg;

    logic        grant;
    logic        pick;
    logic        lock;
    logic        finish;
    logic        sel;
    logic        sel_valid;
    logic        sel_last;
    logic [7:0]  sel_data;
    logic        retry_go;
    logic        load_en;
    logic        rx_ack;
    logic        rx_resend;

    assign lock   = (state_reg != ST_IDLE);
    assign finish = (state_reg == ST_DONE) || (state_reg == ST_ABORT);

    ps2_rr_arbiter2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    ({req_b_valid, req_a_valid}),
        .lock   (lock),
        .update (finish),
        .grant  (grant),
        .pick   (pick)
    );

    // In IDLE the arbiter's pick is the source about to be granted; after
    // that the locked grant selects the source.
    assign sel       = (state_reg == ST_IDLE) ? pick : grant;
    assign sel_valid = sel ? req_b_valid : req_a_valid;
    assign sel_data  = sel ? req_b_data  : req_a_data;
    assign sel_last  = sel ? req_b_last  : req_a_last;

    assign rx_ack    = rx_valid && (rx_data == PS2_ACK);
    assign rx_resend = rx_valid && (rx_data == PS2_RESEND);

    // Next-state and retry bookkeeping; every failure funnels into retry_go.
    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        retry_go   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_a_valid || req_b_valid) state_next = ST_LOAD;
            end
            ST_LOAD: state_next = ST_KICK;
            ST_KICK: begin
                if (sending_data_flag)                       state_next = ST_XMIT;
                else if (cnt_reg == {4'd0, START_TIMEOUT})   retry_go   = 1'b1;
            end
            ST_XMIT: begin
                if (!sending_data_flag) state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // An ACK beats a timeout that expires on the same cycle.
                if (rx_ack)                         state_next = last_reg ? ST_DONE : ST_NEXT;
                else if (rx_resend)                 retry_go   = 1'b1;
                else if (cnt_reg == ACK_TIMEOUT)    retry_go   = 1'b1;
            end
            ST_GAP: state_next = ST_KICK;
            ST_NEXT: begin
                retry_next = 2'd0;
                if (sel_valid) state_next = ST_LOAD;
            end
            ST_DONE: begin
                retry_next = 2'd0;
                state_next = ST_IDLE;
            end
            ST_ABORT: begin
                retry_next = 2'd0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (retry_go) begin
            if (retry_reg < MAX_RETRY) begin
                retry_next = retry_reg + 2'd1;
                state_next = ST_GAP;
            end else begin
                state_next = ST_ABORT;
            end
        end
    end

    assign load_en = (state_next == ST_LOAD) && (state_reg != ST_LOAD);

    // State, retry count and the saturating per-state timeout counter.
    always_ff @(negedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            retry_reg <= 2'd0;
            cnt_reg   <= 20'd0;
        end else begin
            state_reg <= state_next;
            retry_reg <= retry_next;
            if (state_next != state_reg)  cnt_reg <= 20'd0;
            else if (cnt_reg != '1)       cnt_reg <= cnt_reg + 20'd1;
        end
    end

    // Byte capture on entry to LOAD so send_data is stable as send_request rises.
    always_ff @(negedge clock) begin
        if (reset) begin
            data_reg <= 8'd0;
            last_reg <= 1'b0;
        end else if (load_en) begin
            data_reg <= sel_data;
            last_reg <= sel_last;
        end
    end

    // Receive filter: replies are swallowed only while waiting for one.
    always_ff @(negedge clock) begin
        if (reset) begin
            fwd_valid_reg <= 1'b0;
            fwd_data_reg  <= 8'd0;
        end else begin
            fwd_valid_reg <= rx_valid && !((state_reg == ST_WAIT_ACK) && is_reply(rx_data));
            if (rx_valid) fwd_data_reg <= rx_data;
        end
    end

    assign req_a_ready  = (state_reg == ST_LOAD) && !grant;
    assign req_b_ready  = (state_reg == ST_LOAD) &&  grant;
    assign send_request = (state_reg == ST_LOAD) || (state_reg == ST_KICK);
    assign send_data    = data_reg;
    assign fwd_valid    = fwd_valid_reg;
    assign fwd_data     = fwd_data_reg;
    assign done_valid   = finish;
    assign done_src     = finish && grant;
    assign done_error   = (state_reg == ST_ABORT);
    assign busy         = (state_reg != ST_IDLE);

endmodule
